// File: rtl/pmic_pkg.sv
// pmic_pkg: shared types, sizes and helpers for the PMIC power sequencer
package pmic_pkg;
  localparam int NRAILS = 5;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NRAILS - 1);
  typedef enum logic [2:0] {IDLE, UP_LD, UP_WT, UP_PG, ON, DN_LD, DN_WT, FAULT} state_t;
  function automatic logic [NRAILS-1:0] onehot(input logic [IDX_W-1:0] i);
    return NRAILS'(1) << i;
  endfunction
  function automatic logic [IDX_W-1:0] lowest(input logic [NRAILS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = NRAILS - 1; k >= 0; k--) if (v[k]) r = IDX_W'(k);
    return r;
  endfunction
endpackage

// File: rtl/power_sequencer_if.sv
// power_sequencer_if: load/select/expiry handshake with the shared delay timer
interface power_sequencer_if import pmic_pkg::*; ;
  logic tmr_ld;
  logic [NRAILS-1:0] tmr_sel;
  logic [NRAILS-1:0] tmr_T;
  modport master(output tmr_ld, tmr_sel, input tmr_T);
  modport slave(input tmr_ld, tmr_sel, output tmr_T);
endinterface

// File: rtl/pg_watchdog.sv
// pg_watchdog: saturating power-good timeout counter with clear/enable/expired
module pg_watchdog #(
  parameter int PG_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != 8'hff) cnt <= cnt + 1'b1;
  assign expired = cnt == 8'(PG_TIMEOUT - 1);
endmodule

// File: rtl/power_sequencer.sv
// power_sequencer: five-rail PMIC on/off sequencer driving the shared delay timer
// PSEQ_PG_CHECK_EN adds the power-good handshake, pg-drop detection and the FAULT path.
module power_sequencer import pmic_pkg::*; #(
  parameter int PG_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pwr_on_req,
  input  logic               pwr_off_req,
  input  logic [NRAILS-1:0]  pg,
  power_sequencer_if.master  tmr,
  output logic [NRAILS-1:0]  rail_en,
  output logic               pwr_good,
  output logic               busy,
  output logic               fault,
  output logic [IDX_W-1:0]   fault_rail
);
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n, fault_rail_n;
  logic [NRAILS-1:0] rail_en_n;
  logic abort_pend, abort_n, fault_n, busy_n, match, up_now;
  assign match = tmr.tmr_T == tmr.tmr_sel;
  assign up_now = state inside {UP_LD, UP_WT, UP_PG};
`ifdef PSEQ_PG_CHECK_EN
  logic wd_exp;
  logic [NRAILS-1:0] pg_drop;
  assign pg_drop = rail_en & ~pg;
  pg_watchdog #(.PG_TIMEOUT(PG_TIMEOUT)) u_wd (
    .clk,
    .reset_n,
    .clr(state == UP_WT && match && !abort_pend),
    .en(state == UP_PG),
    .expired(wd_exp)
  );
`else
  logic unused_pg;
  assign unused_pg = ^{pg, 8'(PG_TIMEOUT)};
`endif
  always_comb begin
    state_n = state;
    idx_n = idx;
    rail_en_n = rail_en;
    fault_n = fault;
    fault_rail_n = fault_rail;
    case (state)
      IDLE: if (!pwr_off_req && pwr_on_req) begin
        state_n = UP_LD;
        idx_n = '0;
      end
      UP_LD: state_n = UP_WT;
      UP_WT: if (match) begin
        if (abort_pend) begin
          state_n = |rail_en ? DN_LD : IDLE;
          idx_n = |rail_en ? idx - 1'b1 : '0;
        end else begin
          rail_en_n = rail_en | onehot(idx);
`ifdef PSEQ_PG_CHECK_EN
          state_n = UP_PG;
`else
          state_n = idx == LAST_IDX ? ON : UP_LD;
          idx_n = idx == LAST_IDX ? idx : idx + 1'b1;
`endif
        end
      end
`ifdef PSEQ_PG_CHECK_EN
      UP_PG: begin
        if (abort_pend) state_n = DN_LD;
        else if (|(pg & onehot(idx))) begin
          state_n = idx == LAST_IDX ? ON : UP_LD;
          idx_n = idx == LAST_IDX ? idx : idx + 1'b1;
        end else if (wd_exp) begin
          state_n = FAULT;
          fault_n = 1'b1;
          fault_rail_n = idx;
          rail_en_n = '0;
        end
      end
`endif
      ON: begin
        if (pwr_off_req) begin
          state_n = DN_LD;
          idx_n = LAST_IDX;
        end
`ifdef PSEQ_PG_CHECK_EN
        if (|pg_drop) begin
          state_n = FAULT;
          fault_n = 1'b1;
          fault_rail_n = lowest(pg_drop);
          rail_en_n = '0;
        end
`endif
      end
      DN_LD: state_n = DN_WT;
      DN_WT: if (match) begin
        rail_en_n = rail_en & ~onehot(idx);
        state_n = idx == '0 ? IDLE : DN_LD;
        idx_n = idx == '0 ? idx : idx - 1'b1;
      end
      FAULT: if (pwr_off_req) begin
        state_n = IDLE;
        idx_n = '0;
        fault_n = 1'b0;
        fault_rail_n = '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = state_n inside {UP_LD, UP_WT, UP_PG, DN_LD, DN_WT};
    // an abort request survives only while the power-up sequence continues
    abort_n = state_n inside {UP_LD, UP_WT, UP_PG} ? abort_pend | (up_now & pwr_off_req) : 1'b0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      abort_pend <= 1'b0;
      rail_en <= '0;
      fault <= 1'b0;
      fault_rail <= '0;
      busy <= 1'b0;
      pwr_good <= 1'b0;
      tmr.tmr_ld <= 1'b0;
      tmr.tmr_sel <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      abort_pend <= abort_n;
      rail_en <= rail_en_n;
      fault <= fault_n;
      fault_rail <= fault_rail_n;
      busy <= busy_n;
      pwr_good <= state_n == ON;
      tmr.tmr_ld <= state_n == UP_LD || state_n == DN_LD;
      tmr.tmr_sel <= busy_n ? onehot(idx_n) : '0;
    end
endmodule

// File: tb/tb_power_sequencer.sv
// tb_power_sequencer: directed scoreboard bench; acts as the delay timer and pg source
module tb_power_sequencer;
  typedef struct {logic [4:0] sel; logic [4:0] re;} exp_t;
  logic clk = 1'b0;
  logic reset_n, pwr_on_req, pwr_off_req;
  logic [4:0] pg, kill, rail_en;
  logic [4:0] pg_d1 = '0, pg_d2 = '0;
  logic pwr_good, busy, fault;
  logic [2:0] fault_rail;
  logic [4:0] seen, t_sel;
  int t_cnt = 0;
  int total = 0, passed = 0;
  exp_t q[$];

  power_sequencer_if bus();
  power_sequencer #(.PG_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .pwr_on_req(pwr_on_req), .pwr_off_req(pwr_off_req),
    .pg(pg), .tmr(bus), .rail_en(rail_en), .pwr_good(pwr_good), .busy(busy),
    .fault(fault), .fault_rail(fault_rail)
  );

  always #5 clk = ~clk;
  assign pg = pg_d2 & ~kill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [4:0] sel, input logic [4:0] re);
    exp_t e;
    e.sel = sel;
    e.re = re;
    q.push_back(e);
  endtask

  // timer model: fires the loaded select four cycles after each load
  always @(negedge clk) begin
    bus.tmr_T = '0;
    if (t_cnt > 0) begin
      t_cnt--;
      if (t_cnt == 0) bus.tmr_T = t_sel;
    end
    if (bus.tmr_ld) begin
      t_sel = bus.tmr_sel;
      t_cnt = 4;
    end
  end

  always @(negedge clk) begin
    pg_d2 = pg_d1;
    pg_d1 = rail_en;
  end

  always @(negedge clk) if (reset_n === 1'b1 && bus.tmr_ld === 1'b1) begin
    if (q.size() == 0) chk("ld_unexpected", {31'b0, bus.tmr_ld}, 32'd0);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("ld_sel", {27'b0, bus.tmr_sel}, {27'b0, e.sel});
      chk("ld_rail_en", {27'b0, rail_en}, {27'b0, e.re});
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    seen = rail_en;
    for (int n = 0; n < 400 && busy; n++) begin
      @(negedge clk);
      seen |= rail_en;
    end
    chk("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_ld(input logic [4:0] sel);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.tmr_ld && bus.tmr_sel == sel) break;
    end
    chk("ld_seen", {31'b0, bus.tmr_ld}, 32'd1);
  endtask

  task automatic power_up();
    push(5'b00001, 5'b00000);
    push(5'b00010, 5'b00001);
    push(5'b00100, 5'b00011);
    push(5'b01000, 5'b00111);
    push(5'b10000, 5'b01111);
    pwr_on_req = 1'b1;
    for (int n = 0; n < 500 && !pwr_good; n++) @(negedge clk);
    chk("up_pwr_good", {31'b0, pwr_good}, 32'd1);
    chk("up_busy", {31'b0, busy}, 32'd0);
    chk("up_rail_en", {27'b0, rail_en}, 32'h1f);
    chk("up_q_empty", q.size(), 32'd0);
    pwr_on_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    pwr_on_req = 1'b0;
    pwr_off_req = 1'b0;
    kill = '0;
    repeat (3) @(negedge clk);
    chk("rst_rail_en", {27'b0, rail_en}, 32'd0);
    chk("rst_ld_sel", {26'b0, bus.tmr_ld, bus.tmr_sel}, 32'd0);
    chk("rst_flags", {28'b0, pwr_good, busy, fault, |fault_rail}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_busy", {31'b0, busy}, 32'd0);

    power_up();
    push(5'b10000, 5'b11111);
    push(5'b01000, 5'b01111);
    push(5'b00100, 5'b00111);
    push(5'b00010, 5'b00011);
    push(5'b00001, 5'b00001);
    pwr_off_req = 1'b1;
    wait_idle();
    chk("dn_rail_en", {27'b0, rail_en}, 32'd0);
    chk("dn_sel_zero", {27'b0, bus.tmr_sel}, 32'd0);
    chk("dn_pwr_good", {31'b0, pwr_good}, 32'd0);
    chk("dn_q_empty", q.size(), 32'd0);
    pwr_off_req = 1'b0;
    @(negedge clk);

`ifdef PSEQ_PG_CHECK_EN
    kill = 5'b00100;
    push(5'b00001, 5'b00000);
    push(5'b00010, 5'b00001);
    push(5'b00100, 5'b00011);
    pwr_on_req = 1'b1;
    for (int n = 0; n < 300 && !rail_en[2]; n++) @(negedge clk);
    begin
      int n;
      for (n = 0; n < 100 && !fault; n++) @(negedge clk);
      chk("pg_timeout_cycles", n, 32'd16);
    end
    chk("to_fault", {31'b0, fault}, 32'd1);
    chk("to_fault_rail", {29'b0, fault_rail}, 32'd2);
    chk("to_rail_en", {27'b0, rail_en}, 32'd0);
    repeat (6) @(negedge clk);
    chk("to_on_ignored", {30'b0, fault, busy}, 32'd2);
    pwr_on_req = 1'b0;
    pwr_off_req = 1'b1;
    @(negedge clk);
    chk("to_cleared", {28'b0, fault, fault_rail}, 32'd0);
    pwr_off_req = 1'b0;
    kill = '0;
    repeat (4) @(negedge clk);

    power_up();
    kill = 5'b01010;
    pwr_off_req = 1'b1;
    @(negedge clk);
    chk("drop_fault", {31'b0, fault}, 32'd1);
    chk("drop_fault_rail", {29'b0, fault_rail}, 32'd1);
    chk("drop_rail_en", {27'b0, rail_en}, 32'd0);
    chk("drop_flags", {30'b0, pwr_good, busy}, 32'd0);
    @(negedge clk);
    chk("drop_cleared", {31'b0, fault}, 32'd0);
    pwr_off_req = 1'b0;
    kill = '0;
    repeat (4) @(negedge clk);
`endif

    push(5'b00001, 5'b00000);
    push(5'b00010, 5'b00001);
    push(5'b00100, 5'b00011);
    push(5'b00010, 5'b00011);
    push(5'b00001, 5'b00001);
    pwr_on_req = 1'b1;
    wait_ld(5'b00100);
    @(negedge clk);
    pwr_off_req = 1'b1;
    pwr_on_req = 1'b0;
    seen = rail_en;
    for (int n = 0; n < 400 && busy; n++) begin
      @(negedge clk);
      seen |= rail_en;
    end
    chk("abort_idle", {31'b0, busy}, 32'd0);
    chk("abort_rails_seen", {27'b0, seen}, 32'h03);
    chk("abort_rail_en", {27'b0, rail_en}, 32'd0);
    chk("abort_q_empty", q.size(), 32'd0);
    pwr_off_req = 1'b0;
    repeat (3) @(negedge clk);

    power_up();
    push(5'b10000, 5'b11111);
    push(5'b01000, 5'b01111);
    push(5'b00100, 5'b00111);
    pwr_off_req = 1'b1;
    wait_ld(5'b00100);
    @(negedge clk);
    chk("pre_rst_rail_en", {27'b0, rail_en}, 32'h07);
    reset_n = 1'b0;
    #1;
    chk("async_rail_en", {27'b0, rail_en}, 32'd0);
    chk("async_ld_sel", {26'b0, bus.tmr_ld, bus.tmr_sel}, 32'd0);
    chk("async_flags", {28'b0, pwr_good, busy, fault, |fault_rail}, 32'd0);
    q.delete();
    pwr_off_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", {31'b0, busy}, 32'd0);
    chk("post_rst_outputs", {27'b0, rail_en | bus.tmr_sel}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/power_sequencer.md
Name: power_sequencer

Overview:
- Sequences the five PMIC rails on and off by driving the shared delay timer (ld/sel/T interface).
- Power-up: rails 0→4. Each rail enabled after its timer delay, then confirmed by power-good.
- Power-down: rails 4→0, each disabled after its timer delay.
- Sits between host power requests and rail enable pins. Latches faults and performs an immediate all-off shutdown.

Parameters:
- NRAILS, 5, number of rails. Equals the timer sel width; fixed at 5.
- PG_TIMEOUT, 16, cycles allowed for pg[idx] to assert after rail_en[idx] rises. Legal range 2..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pwr_on_req  in  1  level request to power up
- pwr_off_req  in  1  level request to power down or clear a fault
- pg  in  5  per-rail power-good, already synchronised upstream
- tmr_T  in  5  timer expiry pulse; one-hot, one cycle wide
- tmr_ld  out  1  timer load strobe, one cycle wide
- tmr_sel  out  5  one-hot timer/rail select, held stable while waiting
- rail_en  out  5  rail enables
- pwr_good  out  1  all rails up; high only in ON
- busy  out  1  sequencing in progress
- fault  out  1  sticky fault flag
- fault_rail  out  3  index of the faulting rail

Behaviour:
- Reset (asynchronous, any time, including mid-sequence): all outputs 0, state IDLE, idx 0, abort_pend 0.
- All outputs are registered. busy = 1 in UP_LD, UP_WT, UP_PG, DN_LD, DN_WT.

State machine:
- IDLE:
  - pwr_off_req has priority: stay in IDLE.
  - Else pwr_on_req → UP_LD, idx=0.
- UP_LD:
  - tmr_ld=1 for this cycle only; tmr_sel=1<<idx.
  - → UP_WT.
- UP_WT:
  - Wait for tmr_T==tmr_sel. Non-matching or zero tmr_T is ignored.
  - On match with abort_pend=1: do not enable the rail. → DN_LD if any rail_en bit is set, else IDLE. idx = highest enabled rail.
  - On match otherwise: rail_en[idx]<=1, pg_cnt=0 → UP_PG.
- UP_PG:
  - abort_pend=1 → DN_LD, idx unchanged.
  - pg[idx]=1: idx==4 → ON; else idx+1 → UP_LD.
  - Else pg_cnt++. When pg_cnt reaches PG_TIMEOUT-1 → FAULT, fault_rail=idx.
- ON:
  - pwr_good=1.
  - Any pg bit drops → FAULT, fault_rail = lowest dropped index. Fault takes priority over pwr_off_req.
  - Else pwr_off_req → DN_LD, idx=4.
- DN_LD:
  - tmr_ld=1 for one cycle; tmr_sel=1<<idx.
  - → DN_WT.
- DN_WT:
  - On tmr_T match: rail_en[idx]<=0.
  - idx==0 → IDLE (tmr_sel=0); else idx-1 → DN_LD.
- FAULT:
  - rail_en<=0 in the same cycle the FAULT transition is registered. fault=1 sticky. tmr_ld held 0.
  - pwr_on_req is ignored.
  - pwr_off_req → IDLE with fault=0 and fault_rail=0.

Rules:
- abort_pend is set by pwr_off_req in any UP_* state and cleared on leaving the UP_* states. This never issues tmr_ld while the timer is busy; the timer drops loads in that case.
- At most one tmr_ld per rail step. tmr_sel is never 0 while waiting.
- pg bits of disabled rails are ignored in every state.
- idx is 3 bits, range 0..4. No wrap-around: the 4 and 0 boundaries are tested explicitly.
- pg_cnt is 8 bits and saturates.

Optional Feature:
- Macro: PSEQ_PG_CHECK_EN.
- Defined: pg-good handshake as above. UP_PG state present, ON-state pg-drop fault active, FAULT reachable.
- Undefined:
  - UP_WT match → rail_en[idx]<=1, then directly idx+1 → UP_LD, or → ON when idx==4.
  - No UP_PG state. The pg input is unused.
  - fault and fault_rail are tied 0; FAULT is unreachable.
  - abort_pend is evaluated only at UP_WT match.

Decomposition:
- Package pmic_pkg:
  - state enum: IDLE, UP_LD, UP_WT, UP_PG, ON, DN_LD, DN_WT, FAULT
  - NRAILS=5, IDX_W=3
  - one-hot encode function (idx → 5-bit sel)
- Sub-module pg_watchdog: PG_TIMEOUT counter with clear/enable/expired. It is the only natural split.
- The timer is instantiated beside this block at top level, not inside it.

Test Plan:
- Reset, pwr_on_req=1, pg follows rail_en after 2 cycles → five tmr_ld pulses with sel 00001, 00010, 00100, 01000, 10000. rail_en steps 00001→11111. pwr_good=1. busy=0 in ON.
- From ON, pwr_off_req=1 → sel 10000..00001. rail_en steps 11111→01111→…→00000. Ends in IDLE with tmr_sel=0.
- pg[2] held 0 → after PG_TIMEOUT=16 cycles in UP_PG: fault=1, fault_rail=2, rail_en=00000. pwr_on_req ignored. pwr_off_req → IDLE, fault=0.
- In ON, pg[3] and pg[1] drop together with pwr_off_req=1 → FAULT, fault_rail=1, rail_en=00000.
- pwr_off_req during UP_WT at idx=2 → no new tmr_ld until the sel 00100 pulse. rail_en[2] never rises. Power-down then runs sel 00010, then 00001.
- reset_n low while in DN_WT with rail_en=00111 → all outputs 0 immediately. After release: IDLE, no tmr_ld.
